game_flow_ctrl: RTL and testbench
=================================

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter RATING_WIDTH, default 8: width of the rating and high-score counters.
REQ-002 SHALL have parameter LIVES, default 3: lives granted at game start, range 1..15.
REQ-003 SHALL have parameter LEVEL_WIDTH, default 4: width of the level counter.
REQ-004 SHALL have parameter WINS_PER_LEVEL, default 4: wins needed per level-up, range 1..255.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; one clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port i_start, input, 1 bit: start or restart request, level-sensitive.
REQ-008 SHALL have port i_pause_btn, input, 1 bit: pause button; acts on its rising edge only.
REQ-009 SHALL have port i_ready, input, 1 bit: safe-zone generation finished.
REQ-010 SHALL have port i_round_ended, input, 1 bit: round finished; single-cycle pulse.
REQ-011 SHALL have port i_is_win, input, 1 bit: round result; valid only with i_round_ended.
REQ-012 SHALL have port o_game_status, output, 3 bits: current state encoding.
REQ-013 SHALL have port o_is_game_paused, output, 1 bit: high while in PAUSED.
REQ-014 SHALL have port o_current_rating, output, RATING_WIDTH bits: current score.
REQ-015 SHALL have port o_lives, output, 4 bits: remaining lives.
REQ-016 SHALL have port o_level, output, LEVEL_WIDTH bits: current level.
REQ-017 SHALL have port o_high_score, output, RATING_WIDTH bits: best rating since reset.
REQ-018 SHALL have port o_new_record, output, 1 bit: one-cycle pulse when the high score increases.
REQ-019 SHALL have port o_level_start, output, 1 bit: one-cycle pulse in the first cycle of GENERATING.

Function
REQ-020 SHALL use state encoding IDLE=0, GENERATING=1, RUNNING=2, PAUSED=3, GAME_OVER=4; all outputs registered, state change visible one cycle after the causing input.
REQ-021 SHALL, in IDLE or GAME_OVER with i_start=1, enter GENERATING with rating=0, lives=LIVES, level=0, win counter=0.
REQ-022 SHALL, in GENERATING, enter RUNNING on i_ready; it SHALL ignore i_round_ended and pause edges there.
REQ-023 SHALL detect the pause edge as i_pause_btn=1 while the previous-cycle sample was 0; the sampling register clears on reset.
REQ-024 SHALL, in RUNNING with a pause edge and no i_round_ended, enter PAUSED; in PAUSED, a pause edge SHALL return it to RUNNING.
REQ-025 SHALL ignore i_round_ended, i_ready and i_start while in PAUSED.
REQ-026 SHALL, in RUNNING with i_round_ended and i_is_win=1, increment rating (saturating at all-ones), increment the win counter, and enter GENERATING.
REQ-027 SHALL, when a win brings the win counter to WINS_PER_LEVEL, clear the counter and increment level, saturating at all-ones.
REQ-028 SHALL, in RUNNING with i_round_ended and i_is_win=0, clear the win counter, keep rating, and decrement lives; it SHALL enter GAME_OVER if lives was 1, else GENERATING.
REQ-029 SHALL give i_round_ended priority over a pause edge in the same cycle; that pause edge is discarded.
REQ-030 SHALL pulse o_level_start for one cycle on every entry into GENERATING.
REQ-031 SHALL ignore i_start in GENERATING and RUNNING.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, set state=IDLE and o_current_rating, o_level, o_high_score, o_new_record, o_level_start, o_is_game_paused and the win counter to 0, and o_lives=LIVES; this takes precedence over all inputs, including mid-round and while paused.
REQ-033 SHALL be cleared only by rst for the high score, which SHALL survive game restarts.

Configuration
REQ-034 SHALL, with macro GAME_FLOW_HISCORE_EN defined, update o_high_score in the same cycle as a rating increment that exceeds it, and pulse o_new_record for that cycle.
REQ-035 SHALL, without GAME_FLOW_HISCORE_EN, omit the high-score register and tie o_high_score and o_new_record to 0.

Verification
REQ-036 SHALL cover: reset, i_start, then i_ready -> o_level_start=1 for one cycle, then o_game_status=2, o_lives=3, o_current_rating=0.
REQ-037 SHALL cover: four win rounds, each followed by i_ready -> o_current_rating=4, o_level=1, and four o_level_start pulses after the initial one.
REQ-038 SHALL cover: three loss rounds -> o_lives goes 2, 1, then o_game_status=4; i_start then yields o_lives=3, o_current_rating=0.
REQ-039 SHALL cover: pause edge in RUNNING -> o_is_game_paused=1; i_round_ended while paused is ignored; a second edge returns to o_game_status=2; holding the button high causes no re-toggle.
REQ-040 SHALL cover: i_round_ended with i_is_win=1 and a pause edge in the same cycle -> state GENERATING, rating+1, not paused.
REQ-041 SHALL cover, with GAME_FLOW_HISCORE_EN: score 2, lose all lives, restart, score 3 -> o_new_record pulses only on the third win of game 2, o_high_score=3; rst mid-game -> all outputs reset, o_high_score=0.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level flow controller for a round-based game.
// Sequences IDLE -> GENERATING -> RUNNING (<-> PAUSED) -> GAME_OVER and keeps
// the rating, lives, level and win-streak counters.
// Optional feature macro: GAME_FLOW_HISCORE_EN enables the high-score register
// and the new-record pulse; without it both outputs are tied to zero.
// All outputs come straight from flops; reset is synchronous and active-high.

module game_flow_ctrl #(
    parameter int RATING_WIDTH   = 8,
    parameter int LIVES          = 3,
    parameter int LEVEL_WIDTH    = 4,
    parameter int WINS_PER_LEVEL = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_pause_btn,
    input  logic                    i_ready,
    input  logic                    i_round_ended,
    input  logic                    i_is_win,
    output logic [2:0]              o_game_status,
    output logic                    o_is_game_paused,
    output logic [RATING_WIDTH-1:0] o_current_rating,
    output logic [3:0]              o_lives,
    output logic [LEVEL_WIDTH-1:0]  o_level,
    output logic [RATING_WIDTH-1:0] o_high_score,
    output logic                    o_new_record,
    output logic                    o_level_start
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GENERATING = 3'd1,
        ST_RUNNING    = 3'd2,
        ST_PAUSED     = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_t;

    localparam logic [3:0]              LIVES_INIT  = 4'(LIVES);
    localparam logic [7:0]              WINS_LAST   = 8'(WINS_PER_LEVEL - 1);
    localparam logic [RATING_WIDTH-1:0] RATING_MAX  = {RATING_WIDTH{1'b1}};
    localparam logic [RATING_WIDTH-1:0] RATING_ZERO = {RATING_WIDTH{1'b0}};
    localparam logic [RATING_WIDTH-1:0] RATING_ONE  = {{(RATING_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEVEL_WIDTH-1:0]  LEVEL_MAX   = {LEVEL_WIDTH{1'b1}};
    localparam logic [LEVEL_WIDTH-1:0]  LEVEL_ZERO  = {LEVEL_WIDTH{1'b0}};
    localparam logic [LEVEL_WIDTH-1:0]  LEVEL_ONE   = {{(LEVEL_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [RATING_WIDTH-1:0] rating_q, rating_d;
    logic [3:0]              lives_q, lives_d;
    logic [LEVEL_WIDTH-1:0]  level_q, level_d;
    logic [7:0]              wins_q, wins_d;
    logic                    pause_prev_q, pause_prev_d;
    logic                    paused_q, paused_d;
    logic                    level_start_q, level_start_d;
    logic                    pause_edge;

    // Rising-edge detect on the pause button against last cycle's sample.
    always_comb begin
        pause_edge   = i_pause_btn & ~pause_prev_q;
        pause_prev_d = i_pause_btn;
    end

    // Next-state and counter update logic for the game flow FSM.
    always_comb begin
        state_d  = state_q;
        rating_d = rating_q;
        lives_d  = lives_q;
        level_d  = level_q;
        wins_d   = wins_q;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (i_start) begin
                    state_d  = ST_GENERATING;
                    rating_d = RATING_ZERO;
                    lives_d  = LIVES_INIT;
                    level_d  = LEVEL_ZERO;
                    wins_d   = 8'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_GENERATING: begin
                // Round results and pause edges are meaningless until the field exists.
                if (i_ready) begin
                    state_d = ST_RUNNING;
                end else begin
                    state_d = ST_GENERATING;
                end
            end
            ST_RUNNING: begin
                // A round result outranks a simultaneous pause edge, which is dropped.
                if (i_round_ended) begin
                    if (i_is_win) begin
                        if (rating_q != RATING_MAX) begin
                            rating_d = rating_q + RATING_ONE;
                        end else begin
                            rating_d = rating_q;
                        end
                        if (wins_q >= WINS_LAST) begin
                            wins_d = 8'd0;
                            if (level_q != LEVEL_MAX) begin
                                level_d = level_q + LEVEL_ONE;
                            end else begin
                                level_d = level_q;
                            end
                        end else begin
                            wins_d = wins_q + 8'd1;
                        end
                        state_d = ST_GENERATING;
                    end else begin
                        wins_d = 8'd0;
                        if (lives_q != 4'd0) begin
                            lives_d = lives_q - 4'd1;
                        end else begin
                            lives_d = 4'd0;
                        end
                        if (lives_q <= 4'd1) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            state_d = ST_GENERATING;
                        end
                    end
                end else if (pause_edge) begin
                    state_d = ST_PAUSED;
                end else begin
                    state_d = ST_RUNNING;
                end
            end
            ST_PAUSED: begin
                // Only the pause button is honoured while paused.
                if (pause_edge) begin
                    state_d = ST_RUNNING;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered status flags derived from the upcoming state.
    always_comb begin
        paused_d      = (state_d == ST_PAUSED);
        level_start_d = (state_d == ST_GENERATING) && (state_q != ST_GENERATING);
    end

    // Main state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rating_q      <= RATING_ZERO;
            lives_q       <= LIVES_INIT;
            level_q       <= LEVEL_ZERO;
            wins_q        <= 8'd0;
            pause_prev_q  <= 1'b0;
            paused_q      <= 1'b0;
            level_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rating_q      <= rating_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            wins_q        <= wins_d;
            pause_prev_q  <= pause_prev_d;
            paused_q      <= paused_d;
            level_start_q <= level_start_d;
        end
    end

`ifdef GAME_FLOW_HISCORE_EN
    logic [RATING_WIDTH-1:0] hiscore_q, hiscore_d;
    logic                    new_record_q, new_record_d;

    // High score follows the rating in the same cycle it is beaten.
    always_comb begin
        hiscore_d    = hiscore_q;
        new_record_d = 1'b0;
        if (rating_d > hiscore_q) begin
            hiscore_d    = rating_d;
            new_record_d = 1'b1;
        end else begin
            hiscore_d    = hiscore_q;
            new_record_d = 1'b0;
        end
    end

    // High-score registers; cleared only by reset, kept across restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            hiscore_q    <= RATING_ZERO;
            new_record_q <= 1'b0;
        end else begin
            hiscore_q    <= hiscore_d;
            new_record_q <= new_record_d;
        end
    end

    assign o_high_score = hiscore_q;
    assign o_new_record = new_record_q;
`else
    assign o_high_score = RATING_ZERO;
    assign o_new_record = 1'b0;
`endif

    assign o_game_status    = state_q;
    assign o_is_game_paused = paused_q;
    assign o_current_rating = rating_q;
    assign o_lives          = lives_q;
    assign o_level          = level_q;
    assign o_level_start    = level_start_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Testbench for game_flow_ctrl: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences (saturation, high score, reset mid-game).
// High-score expectations depend on GAME_FLOW_HISCORE_EN.

module tb_game_flow_ctrl;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic       i_pause_btn;
    logic       i_ready;
    logic       i_round_ended;
    logic       i_is_win;
    logic [2:0] o_game_status;
    logic       o_is_game_paused;
    logic [7:0] o_current_rating;
    logic [3:0] o_lives;
    logic [3:0] o_level;
    logic [7:0] o_high_score;
    logic       o_new_record;
    logic       o_level_start;

    int n_checks = 0;
    int n_pass   = 0;

    game_flow_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (i_start),
        .i_pause_btn      (i_pause_btn),
        .i_ready          (i_ready),
        .i_round_ended    (i_round_ended),
        .i_is_win         (i_is_win),
        .o_game_status    (o_game_status),
        .o_is_game_paused (o_is_game_paused),
        .o_current_rating (o_current_rating),
        .o_lives          (o_lives),
        .o_level          (o_level),
        .o_high_score     (o_high_score),
        .o_new_record     (o_new_record),
        .o_level_start    (o_level_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, start, pause, ready, rend, win;
        logic [2:0] st;
        logic       pa;
        logic [7:0] rat;
        logic [3:0] liv;
        logic [3:0] lev;
        logic       ls;
        logic       nr;
        logic [7:0] hs;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [7:0] hsx(input logic [7:0] x);
`ifdef GAME_FLOW_HISCORE_EN
        return x;
`else
        return 8'd0;
`endif
    endfunction

    function automatic logic nrx(input logic b);
`ifdef GAME_FLOW_HISCORE_EN
        return b;
`else
        return 1'b0;
`endif
    endfunction

    function automatic vec_t mk(input logic r, s, p, rd, re, w,
                                input logic [2:0] st, input logic pa,
                                input logic [7:0] rat, input logic [3:0] liv,
                                input logic [3:0] lev, input logic ls,
                                input logic nr, input logic [7:0] hs);
        vec_t v;
        v.rst = r; v.start = s; v.pause = p; v.ready = rd; v.rend = re; v.win = w;
        v.st = st; v.pa = pa; v.rat = rat; v.liv = liv; v.lev = lev;
        v.ls = ls; v.nr = nrx(nr); v.hs = hsx(hs);
        return v;
    endfunction

    task automatic drive(input logic r, s, p, rd, re, w);
        rst = r; i_start = s; i_pause_btn = p; i_ready = rd;
        i_round_ended = re; i_is_win = w;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [2:0] st, input logic pa,
                           input logic [7:0] rat, input logic [3:0] liv, input logic [3:0] lev,
                           input logic ls, input logic nr, input logic [7:0] hs);
        n_checks++;
        if (o_game_status === st && o_is_game_paused === pa && o_current_rating === rat &&
            o_lives === liv && o_level === lev && o_level_start === ls &&
            o_new_record === nrx(nr) && o_high_score === hsx(hs)) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got st=%0d pa=%0d rat=%0d liv=%0d lev=%0d ls=%0d nr=%0d hs=%0d expected st=%0d pa=%0d rat=%0d liv=%0d lev=%0d ls=%0d nr=%0d hs=%0d",
                     name, o_game_status, o_is_game_paused, o_current_rating, o_lives, o_level,
                     o_level_start, o_new_record, o_high_score,
                     st, pa, rat, liv, lev, ls, nrx(nr), hsx(hs));
        end
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_pause_btn = 1'b0; i_ready = 1'b0;
        i_round_ended = 1'b0; i_is_win = 1'b0;

        //            rst  st   pa   rdy  re   win   st    pa   rat  liv  lev  ls   nr   hs
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0,8'd0,4'd3,4'd0,1'b0,1'b0,8'd0)); // 0 reset
        tbl.push_back(mk(1'b1,1'b1,1'b1,1'b1,1'b1,1'b1, 3'd0,1'b0,8'd0,4'd3,4'd0,1'b0,1'b0,8'd0)); // 1 reset beats inputs
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0,1'b0,8'd0,4'd3,4'd0,1'b0,1'b0,8'd0)); // 2 idle
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1,1'b0,8'd0,4'd3,4'd0,1'b1,1'b0,8'd0)); // 3 start
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1,1'b0,8'd0,4'd3,4'd0,1'b0,1'b0,8'd0)); // 4 start held
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd2,1'b0,8'd0,4'd3,4'd0,1'b0,1'b0,8'd0)); // 5 ready
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 3'd2,1'b0,8'd0,4'd3,4'd0,1'b0,1'b0,8'd0)); // 6 start ignored
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 3'd1,1'b0,8'd1,4'd3,4'd0,1'b1,1'b1,8'd1)); // 7 win1
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd2,1'b0,8'd1,4'd3,4'd0,1'b0,1'b0,8'd1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 3'd1,1'b0,8'd2,4'd3,4'd0,1'b1,1'b1,8'd2)); // 9 win2
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd2,1'b0,8'd2,4'd3,4'd0,1'b0,1'b0,8'd2));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 3'd1,1'b0,8'd3,4'd3,4'd0,1'b1,1'b1,8'd3)); // 11 win3
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd2,1'b0,8'd3,4'd3,4'd0,1'b0,1'b0,8'd3));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 3'd1,1'b0,8'd4,4'd3,4'd1,1'b1,1'b1,8'd4)); // 13 win4 level up
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd2,1'b0,8'd4,4'd3,4'd1,1'b0,1'b0,8'd4));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd1,1'b0,8'd4,4'd2,4'd1,1'b1,1'b0,8'd4)); // 15 loss
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 3'd1,1'b0,8'd4,4'd2,4'd1,1'b0,1'b0,8'd4)); // 16 round end ignored
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 3'd1,1'b0,8'd4,4'd2,4'd1,1'b0,1'b0,8'd4)); // 17 pause ignored
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd2,1'b0,8'd4,4'd2,4'd1,1'b0,1'b0,8'd4));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 3'd3,1'b1,8'd4,4'd2,4'd1,1'b0,1'b0,8'd4)); // 19 pause
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 3'd3,1'b1,8'd4,4'd2,4'd1,1'b0,1'b0,8'd4)); // 20 held, round ignored
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 3'd3,1'b1,8'd4,4'd2,4'd1,1'b0,1'b0,8'd4)); // 21 start/ready ignored
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 3'd2,1'b0,8'd4,4'd2,4'd1,1'b0,1'b0,8'd4)); // 22 resume
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 3'd2,1'b0,8'd4,4'd2,4'd1,1'b0,1'b0,8'd4)); // 23 held
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 3'd2,1'b0,8'd4,4'd2,4'd1,1'b0,1'b0,8'd4)); // 24 held
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd2,1'b0,8'd4,4'd2,4'd1,1'b0,1'b0,8'd4));
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 3'd1,1'b0,8'd5,4'd2,4'd1,1'b1,1'b1,8'd5)); // 26 win beats pause
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd2,1'b0,8'd5,4'd2,4'd1,1'b0,1'b0,8'd5));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd1,1'b0,8'd5,4'd1,4'd1,1'b1,1'b0,8'd5)); // 28 loss
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd2,1'b0,8'd5,4'd1,4'd1,1'b0,1'b0,8'd5));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 3'd4,1'b0,8'd5,4'd0,4'd1,1'b0,1'b0,8'd5)); // 30 game over
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 3'd4,1'b0,8'd5,4'd0,4'd1,1'b0,1'b0,8'd5));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 3'd4,1'b0,8'd5,4'd0,4'd1,1'b0,1'b0,8'd5)); // 32 ignored
        tbl.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1,1'b0,8'd0,4'd3,4'd0,1'b1,1'b0,8'd5)); // 33 restart
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd2,1'b0,8'd0,4'd3,4'd0,1'b0,1'b0,8'd5));
        tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 3'd1,1'b0,8'd1,4'd3,4'd0,1'b1,1'b0,8'd5)); // 35 no record
        tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 3'd0,1'b0,8'd0,4'd3,4'd0,1'b0,1'b0,8'd0)); // 36 reset mid-game
        tbl.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 3'd0,1'b0,8'd0,4'd3,4'd0,1'b0,1'b0,8'd0)); // 37 pause in idle

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].pause, tbl[i].ready, tbl[i].rend, tbl[i].win);
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].pa, tbl[i].rat, tbl[i].liv,
                    tbl[i].lev, tbl[i].ls, tbl[i].nr, tbl[i].hs);
        end

        // Saturation of rating and level over many wins.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 300; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            if (k == 60) begin
                chk("sat_level15_at60", {28'd0, o_level}, 32'd15);
            end
            if (k == 255) begin
                chk("sat_rating255", {24'd0, o_current_rating}, 32'd255);
                chk("sat_record_at255", {31'd0, o_new_record}, {31'd0, nrx(1'b1)});
            end
            if (k == 256) begin
                chk("sat_rating_hold", {24'd0, o_current_rating}, 32'd255);
                chk("sat_no_record_256", {31'd0, o_new_record}, 32'd0);
            end
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk_all("sat_final", 3'd2, 1'b0, 8'd255, 4'd3, 4'd15, 1'b0, 1'b0, 8'd255);

        // High score across a restart, then reset while paused.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_all("hs_g1_win1", 3'd1, 1'b0, 8'd1, 4'd3, 4'd0, 1'b1, 1'b1, 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_all("hs_g1_win2", 3'd1, 1'b0, 8'd2, 4'd3, 4'd0, 1'b1, 1'b1, 8'd2);
        for (int l = 0; l < 3; l++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("hs_g1_loss%0d_lives", l), {28'd0, o_lives}, 32'(2 - l));
        end
        chk("hs_g1_over", {29'd0, o_game_status}, 32'd4);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("hs_g2_start", 3'd1, 1'b0, 8'd0, 4'd3, 4'd0, 1'b1, 1'b0, 8'd2);
        for (int w = 1; w <= 3; w++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            chk_all($sformatf("hs_g2_win%0d", w), 3'd1, 1'b0, 8'(w), 4'd3, 4'd0, 1'b1,
                    (w == 3) ? 1'b1 : 1'b0, (w == 3) ? 8'd3 : 8'd2);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("hs_paused", 3'd3, 1'b1, 8'd3, 4'd3, 4'd0, 1'b0, 1'b0, 8'd3);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_all("rst_while_paused", 3'd0, 1'b0, 8'd0, 4'd3, 4'd0, 1'b0, 1'b0, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
